wbu_pcq: RTL and testbench
==========================

# wbu_pcq

Parametrised write-back / next-PC unit sitting between EXU and IFU in the single-issue core. On each EXU handshake it commits register/CSR write enables, computes the next architectural PC (sequential, branch, JALR, CSR-redirect) and pushes it into a DEPTH-entry queue that feeds IFU. The queue decouples EXU from IFU back-pressure. A 64-bit retire counter is added. DEPTH=1 reproduces the previous one-outstanding-PC behaviour.

## Interface

- XLEN, 32: datapath and PC width.
- DEPTH, 2: next-PC queue entries; legal ≥1, need not be a power of two.
- RESET_PC, 32'h8000_0000: boot PC, XLEN bits; SOC builds set 32'h3000_0000.
- ILEN_BYTES, 4: sequential increment.

- clk  in  1  sole clock; all state on posedge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- exu_valid  in  1  EXU result valid.
- exu_ready  out  1  unit can accept an EXU result.
- pc_sel  in  2  next-PC source: SEQ=0, BR=1, JALR=2, CSR=3.
- imm  in  XLEN  immediate.
- rs1  in  XLEN  rs1 value.
- csr_rdata  in  XLEN  mtvec/mepc value for CSR redirect.
- regw, csrw  in  1  instruction writes GPR / CSR.
- reg_wen, csr_wen  out  1  write strobes to register file / CSR file.
- ifu_valid  out  1  queue head valid.
- ifu_ready  in  1  IFU takes head.
- ifu_pc  out  XLEN  queue head PC.
- pc  out  XLEN  architectural PC of the instruction currently owned by EXU.
- q_count  out  $clog2(DEPTH+1)  queue occupancy.
- retired  out  64  instructions committed since reset.

## Operation

- acc = exu_valid & exu_ready; pop = ifu_valid & ifu_ready.
- exu_ready = (q_count < DEPTH); registered-count based only, no combinational path from ifu_ready.
- Next PC, all arithmetic modulo 2^XLEN:
  - SEQ: pc + ILEN_BYTES.
  - BR: pc + imm.
  - JALR: (rs1 + imm) & ~1, with bit 0 cleared.
  - CSR: csr_rdata.
- On acc: pc <= npc; npc written at tail; tail advances; retired += 1, wrapping at 2^64.
- reg_wen = acc & regw; csr_wen = acc & csrw. Both are combinational and single-cycle.
- On pop: head advances. ifu_pc = entry[head] whenever ifu_valid.
- Pointers wrap from DEPTH-1 to 0.
- q_count update:
  - acc only: +1.
  - pop only: −1.
  - both: unchanged. Legal only when not full, since full ⇒ exu_ready=0.
- Empty: ifu_valid=0; ifu_pc is don't-care.

## Timing

- Reset, applied asynchronously and effective immediately, also mid-transaction:
  - pc=RESET_PC; entry[0]=RESET_PC; head=0; tail=1 mod DEPTH; q_count=1.
  - ifu_valid=1, so IFU fetches the boot PC first.
  - exu_ready = (DEPTH>1); retired=0.
  - reg_wen and csr_wen are forced 0 while rst=0.
- Release is synchronous to clk. The first acc/pop is possible on the first posedge after rst rises.
- Latency:
  - acc at edge N → ifu_valid/ifu_pc valid after edge N, when the queue was empty.
  - acc at edge N → pc updated after edge N.
- Write strobes are in the same cycle as the handshake; data paths are not registered here.
- Full (q_count=DEPTH): exu_ready=0. A pop in that cycle raises exu_ready the next cycle, with no same-cycle bypass.
- Empty: pop is impossible. acc and IFU request in the same cycle → ifu_valid the next cycle, with no bypass.
- exu_valid held while exu_ready=0: inputs must remain stable, and no strobe fires.

## Structure

- Package wbu_pkg holds:
  - pc_sel_e enum: SEQ/BR/JALR/CSR.
  - ILEN_BYTES default constant.
  - RESET_PC defaults: SIM 32'h8000_0000, SOC 32'h3000_0000.
- Sub-module pc_fifo(WIDTH, DEPTH, INIT): storage, head/tail/count, asynchronous active-low reset preloading one INIT entry.
- The top level holds the next-PC mux/adder, the pc register, the strobes and the retire counter.

## Test plan

- Reset, DEPTH=2 → ifu_valid=1, ifu_pc=0x8000_0000, q_count=1, exu_ready=1, retired=0. Pop it → q_count=0.
- Accepts from pc=0x8000_0000, IFU stalled:
  - SEQ → queue holds 0x8000_0004.
  - BR imm=−8 → queue holds 0x7FFF_FFFC.
  - Queue is now full → exu_ready=0.
  - Pop once → exu_ready=1 the next cycle.
- JALR: rs1=0x8000_0101, imm=2 → npc=0x8000_0102. JALR: rs1=0xFFFF_FFFF, imm=2 → npc=0x0000_0000, with bit 0 cleared and wrap.
- Strobes:
  - CSR sel, csr_rdata=0x8000_0200, csrw=1, regw=1 → csr_wen=reg_wen=1 for exactly the acc cycle; pc=0x8000_0200.
  - exu_valid=1 while full → both strobes 0.
- DEPTH=3: 10 back-to-back acc with simultaneous pop, for pointer wrap → FIFO order preserved, q_count constant, retired=10.
- Assert rst=0 mid-burst, asynchronous to clk → outputs return to reset values before the next edge; the queue holds only RESET_PC.

Source files
------------

// File: rtl/wbu_pcq_pkg.sv
// wbu_pkg: shared types and defaults for the write-back / next-PC unit.
//   pc_sel_e         : next-PC source encoding driven by EXU.
//   DEF_ILEN_BYTES   : default sequential PC increment.
//   RESET_PC_SIM/SOC : boot PC defaults for simulation and SoC builds.
package wbu_pkg;

  typedef enum logic [1:0] {
    SEQ  = 2'd0,
    BR   = 2'd1,
    JALR = 2'd2,
    CSR  = 2'd3
  } pc_sel_e;

  localparam int          DEF_ILEN_BYTES = 4;
  localparam logic [31:0] RESET_PC_SIM   = 32'h8000_0000;
  localparam logic [31:0] RESET_PC_SOC   = 32'h3000_0000;

endpackage

// File: rtl/wbu_pcq_pc_fifo.sv
// pc_fifo: small circular queue of PCs between the write-back unit and IFU.
// Reset preloads a single INIT entry so the fetch unit sees the boot PC
// immediately after reset.
// Ports:
//   clk, rst (async, active-low)
//   push/wdata : write at tail (caller guarantees not full)
//   pop        : advance head (caller guarantees not empty)
//   rdata      : entry at head
//   count      : occupancy, 0..DEPTH
module pc_fifo #(
  parameter int               WIDTH = 32,
  parameter int               DEPTH = 2,
  parameter logic [WIDTH-1:0] INIT  = '0,
  localparam int              CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage: every slot reset to INIT; only slot 0 counts as occupied.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT;
    end else if (push) begin
      mem[tail] <= wdata;
    end
  end

  // Head/tail pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= PW'(1 % DEPTH);
      count <= CW'(1);
    end else begin
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[head];

endmodule

// File: rtl/wbu_pcq.sv
// wbu_pcq: write-back / next-PC unit between EXU and IFU.
// On each EXU handshake it raises the register/CSR write strobes, computes
// the next architectural PC and queues it for IFU; also counts retirements.
// Ports:
//   clk, rst (async, active-low)
//   exu_valid/exu_ready, pc_sel, imm, rs1, csr_rdata, regw, csrw : EXU side
//   reg_wen, csr_wen : write strobes, same cycle as the handshake
//   ifu_valid/ifu_ready/ifu_pc : queue head towards IFU
//   pc       : PC of the instruction currently owned by EXU
//   q_count  : queue occupancy
//   retired  : instructions committed since reset
module wbu_pcq
  import wbu_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              DEPTH      = 2,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_SIM),
  parameter int              ILEN_BYTES = DEF_ILEN_BYTES,
  localparam int             CW         = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exu_valid,
  output logic            exu_ready,
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] csr_rdata,
  input  logic            regw,
  input  logic            csrw,
  output logic            reg_wen,
  output logic            csr_wen,
  output logic            ifu_valid,
  input  logic            ifu_ready,
  output logic [XLEN-1:0] ifu_pc,
  output logic [XLEN-1:0] pc,
  output logic [CW-1:0]   q_count,
  output logic [63:0]     retired
);

  logic            acc;
  logic            pop;
  logic [XLEN-1:0] npc;

  // Ready depends only on the registered occupancy, never on ifu_ready.
  assign exu_ready = (q_count < CW'(DEPTH));
  assign ifu_valid = (q_count != '0);
  assign acc       = exu_valid & exu_ready;
  assign pop       = ifu_valid & ifu_ready;

  // Strobes are additionally gated by reset so nothing is written while held.
  assign reg_wen = acc & regw & rst;
  assign csr_wen = acc & csrw & rst;

  // Next-PC selection; all sums wrap modulo 2^XLEN, JALR clears bit 0.
  always_comb begin
    npc = pc + XLEN'(ILEN_BYTES);
    case (pc_sel_e'(pc_sel))
      SEQ:  npc = pc + XLEN'(ILEN_BYTES);
      BR:   npc = pc + imm;
      JALR: npc = (rs1 + imm) & ~XLEN'(1);
      CSR:  npc = csr_rdata;
      default: npc = pc + XLEN'(ILEN_BYTES);
    endcase
  end

  // Architectural PC and retire counter advance together on each accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= RESET_PC;
      retired <= '0;
    end else if (acc) begin
      pc      <= npc;
      retired <= retired + 64'd1;
    end
  end

  pc_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH),
    .INIT  (RESET_PC)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (acc),
    .pop   (pop),
    .wdata (npc),
    .rdata (ifu_pc),
    .count (q_count)
  );

endmodule

// File: tb/tb_wbu_pcq.sv
// tb_wbu_pcq: scoreboard bench for wbu_pcq with DEPTH=2 (instance a) and
// DEPTH=3 (instance b). Expected next-PCs are pushed when an accept is
// driven and compared against ifu_pc when IFU pops.
module tb_wbu_pcq;
  import wbu_pkg::*;

  localparam logic [31:0] BOOT = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_exu_valid, a_exu_ready, a_regw, a_csrw, a_reg_wen, a_csr_wen;
  logic        a_ifu_valid, a_ifu_ready;
  logic [1:0]  a_pc_sel, a_q_count;
  logic [31:0] a_imm, a_rs1, a_csr_rdata, a_ifu_pc, a_pc;
  logic [63:0] a_retired;

  logic        b_exu_valid, b_exu_ready, b_regw, b_csrw, b_reg_wen, b_csr_wen;
  logic        b_ifu_valid, b_ifu_ready;
  logic [1:0]  b_pc_sel, b_q_count;
  logic [31:0] b_imm, b_rs1, b_csr_rdata, b_ifu_pc, b_pc;
  logic [63:0] b_retired;

  wbu_pcq #(.XLEN(32), .DEPTH(2), .RESET_PC(BOOT), .ILEN_BYTES(4)) u_dut_a (
    .clk(clk), .rst(rst), .exu_valid(a_exu_valid), .exu_ready(a_exu_ready),
    .pc_sel(a_pc_sel), .imm(a_imm), .rs1(a_rs1), .csr_rdata(a_csr_rdata),
    .regw(a_regw), .csrw(a_csrw), .reg_wen(a_reg_wen), .csr_wen(a_csr_wen),
    .ifu_valid(a_ifu_valid), .ifu_ready(a_ifu_ready), .ifu_pc(a_ifu_pc),
    .pc(a_pc), .q_count(a_q_count), .retired(a_retired));

  wbu_pcq #(.XLEN(32), .DEPTH(3), .RESET_PC(BOOT), .ILEN_BYTES(4)) u_dut_b (
    .clk(clk), .rst(rst), .exu_valid(b_exu_valid), .exu_ready(b_exu_ready),
    .pc_sel(b_pc_sel), .imm(b_imm), .rs1(b_rs1), .csr_rdata(b_csr_rdata),
    .regw(b_regw), .csrw(b_csrw), .reg_wen(b_reg_wen), .csr_wen(b_csr_wen),
    .ifu_valid(b_ifu_valid), .ifu_ready(b_ifu_ready), .ifu_pc(b_ifu_pc),
    .pc(b_pc), .q_count(b_q_count), .retired(b_retired));

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] expQa[$];
  logic [31:0] expQb[$];
  logic [31:0] mPcA, mPcB;
  int          mCountA, mCountB;
  longint      mRetA, mRetB;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] calcNpc(input logic [1:0] sel, input logic [31:0] cur,
                                          input logic [31:0] im, input logic [31:0] r1,
                                          input logic [31:0] cd);
    case (sel)
      2'd0:    return cur + 32'd4;
      2'd1:    return cur + im;
      2'd2:    return (r1 + im) & 32'hFFFF_FFFE;
      default: return cd;
    endcase
  endfunction

  // One EXU request cycle on instance a; accept happens only if not full.
  task automatic applyStimulus(input logic [1:0] sel, input logic [31:0] im,
                               input logic [31:0] r1, input logic [31:0] cd,
                               input logic rw, input logic cw);
    logic        rdy;
    logic [31:0] npc;
    rdy = (mCountA < 2);
    npc = calcNpc(sel, mPcA, im, r1, cd);
    a_exu_valid = 1'b1; a_pc_sel = sel; a_imm = im; a_rs1 = r1;
    a_csr_rdata = cd; a_regw = rw; a_csrw = cw;
    #1;
    checkOutput("a_exu_ready", 64'(a_exu_ready), 64'(rdy));
    checkOutput("a_reg_wen",   64'(a_reg_wen),   64'(rdy & rw));
    checkOutput("a_csr_wen",   64'(a_csr_wen),   64'(rdy & cw));
    @(posedge clk);
    if (rdy) begin
      expQa.push_back(npc);
      mPcA = npc;
      mCountA++;
      mRetA++;
    end
    #1;
    a_exu_valid = 1'b0; a_regw = 1'b0; a_csrw = 1'b0;
    #1;
    checkOutput("a_pc",       64'(a_pc),      64'(mPcA));
    checkOutput("a_q_count",  64'(a_q_count), 64'(mCountA));
    checkOutput("a_retired",  a_retired,      64'(mRetA));
    checkOutput("a_strobe_off", 64'({a_reg_wen, a_csr_wen}), 64'd0);
  endtask

  // One IFU pop on instance a, comparing the head against the scoreboard.
  task automatic popA();
    logic [31:0] exp;
    a_ifu_ready = 1'b1;
    #1;
    checkOutput("a_ifu_valid", 64'(a_ifu_valid), 64'(mCountA != 0));
    checkOutput("a_exu_ready_pre", 64'(a_exu_ready), 64'(mCountA < 2));
    if (expQa.size() == 0) begin
      vectors++; miscompares++;
      $display("[TB] FAIL a_scoreboard: got empty queue, expected an entry");
    end else begin
      exp = expQa.pop_front();
      checkOutput("a_ifu_pc", 64'(a_ifu_pc), 64'(exp));
    end
    @(posedge clk);
    if (mCountA > 0) mCountA--;
    #1;
    a_ifu_ready = 1'b0;
    #1;
    checkOutput("a_q_count_pop", 64'(a_q_count), 64'(mCountA));
    checkOutput("a_exu_ready_post", 64'(a_exu_ready), 64'(mCountA < 2));
  endtask

  initial begin
    logic [31:0] npc;
    logic [31:0] exp;
    rst = 1'b0;
    a_exu_valid = 0; a_ifu_ready = 0; a_pc_sel = 0; a_imm = 0; a_rs1 = 0;
    a_csr_rdata = 0; a_regw = 0; a_csrw = 0;
    b_exu_valid = 0; b_ifu_ready = 0; b_pc_sel = 0; b_imm = 0; b_rs1 = 0;
    b_csr_rdata = 0; b_regw = 0; b_csrw = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;

    // Reset state
    expQa.push_back(BOOT); mPcA = BOOT; mCountA = 1; mRetA = 0;
    expQb.push_back(BOOT); mPcB = BOOT; mCountB = 1; mRetB = 0;
    checkOutput("rst_a_ifu_valid", 64'(a_ifu_valid), 64'd1);
    checkOutput("rst_a_ifu_pc",    64'(a_ifu_pc),    64'(BOOT));
    checkOutput("rst_a_q_count",   64'(a_q_count),   64'd1);
    checkOutput("rst_a_exu_ready", 64'(a_exu_ready), 64'd1);
    checkOutput("rst_a_retired",   a_retired,        64'd0);
    checkOutput("rst_a_pc",        64'(a_pc),        64'(BOOT));
    checkOutput("rst_b_exu_ready", 64'(b_exu_ready), 64'd1);

    // Drain the boot PC, then fill the DEPTH=2 queue with IFU stalled
    popA();
    checkOutput("a_empty_valid", 64'(a_ifu_valid), 64'd0);
    applyStimulus(2'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus(2'd1, 32'hFFFF_FFF8, 32'd0, 32'd0, 1'b0, 1'b0);
    // Full: request is refused and strobes stay low
    applyStimulus(2'd3, 32'd0, 32'd0, 32'h1234_5678, 1'b1, 1'b1);
    popA();
    popA();

    // JALR with bit-0 clear and wrap-around
    applyStimulus(2'd2, 32'd2, 32'h8000_0101, 32'd0, 1'b1, 1'b0);
    applyStimulus(2'd2, 32'd2, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    popA();
    popA();

    // CSR redirect with both strobes
    applyStimulus(2'd3, 32'd0, 32'd0, 32'h8000_0200, 1'b1, 1'b1);
    popA();

    // DEPTH=3: 10 back-to-back accepts with simultaneous pops
    for (int i = 0; i < 10; i++) begin
      b_exu_valid = 1'b1;
      b_ifu_ready = 1'b1;
      b_pc_sel    = (i % 2 == 0) ? 2'd1 : 2'd0;
      b_imm       = 32'h10 * 32'(i + 1);
      npc = calcNpc(b_pc_sel, mPcB, b_imm, b_rs1, b_csr_rdata);
      #1;
      checkOutput("b_ifu_valid", 64'(b_ifu_valid), 64'd1);
      checkOutput("b_exu_ready", 64'(b_exu_ready), 64'd1);
      checkOutput("b_q_count",   64'(b_q_count),   64'(mCountB));
      exp = expQb.pop_front();
      checkOutput("b_ifu_pc",    64'(b_ifu_pc),    64'(exp));
      @(posedge clk);
      expQb.push_back(npc);
      mPcB = npc;
      mRetB++;
      #1;
    end
    b_exu_valid = 1'b0;
    b_ifu_ready = 1'b0;
    #1;
    checkOutput("b_retired", b_retired,      64'(mRetB));
    checkOutput("b_q_count_end", 64'(b_q_count), 64'(mCountB));
    checkOutput("b_pc", 64'(b_pc), 64'(mPcB));

    // Asynchronous reset in the middle of an accept burst
    b_exu_valid = 1'b1; b_regw = 1'b1; b_pc_sel = 2'd0;
    @(posedge clk);
    #3;
    checkOutput("b_reg_wen_burst", 64'(b_reg_wen), 64'd1);
    rst = 1'b0;
    #1;
    checkOutput("arst_b_reg_wen",   64'(b_reg_wen),   64'd0);
    checkOutput("arst_b_pc",        64'(b_pc),        64'(BOOT));
    checkOutput("arst_b_q_count",   64'(b_q_count),   64'd1);
    checkOutput("arst_b_ifu_valid", 64'(b_ifu_valid), 64'd1);
    checkOutput("arst_b_ifu_pc",    64'(b_ifu_pc),    64'(BOOT));
    checkOutput("arst_b_retired",   b_retired,        64'd0);
    checkOutput("arst_b_exu_ready", 64'(b_exu_ready), 64'd1);
    b_exu_valid = 1'b0; b_regw = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    b_ifu_ready = 1'b1;
    #1;
    checkOutput("arst_b_head", 64'(b_ifu_pc), 64'(BOOT));
    @(posedge clk);
    #1;
    b_ifu_ready = 1'b0;
    #1;
    checkOutput("arst_b_only_one", 64'(b_ifu_valid), 64'd0);
    checkOutput("arst_b_q_empty",  64'(b_q_count),   64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
